// File: rtl/truth_table_inverter.sv
// truth_table_inverter: reverse-lookup scanner for a 4-in/10-out function unit.
// Steps every input code 0..15 onto probe, waits for the unit to settle, then
// compares its response against a latched target word. It reports the lowest
// matching code, the number of matches and a per-code hit map.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; probe parked at 0, busy low
// SETTLE  | probe held while the settle down-counter runs to 0
// COMPARE | one cycle: sample resp, record hit, advance or finish
// DONE    | one cycle: done pulse, busy low, results frozen
module truth_table_inverter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [9:0]  CARE_MASK     = 10'b1100111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop_first,
  input  logic [9:0]  target,
  output logic [3:0]  probe,
  input  logic [9:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [3:0]  first_idx,
  output logic [4:0]  match_count,
  output logic [15:0] match_map
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Loading SETTLE_CYCLES-1 and leaving on zero makes SETTLE last exactly
  // SETTLE_CYCLES cycles.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [9:0] target_q;
  logic       stop_first_q;
  logic       hit;

  // Masked compare of the live response against the latched target.
  assign hit = ((resp ^ target_q) & CARE_MASK) == 10'd0;

  // Scan sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      target_q     <= 10'd0;
      stop_first_q <= 1'b0;
      probe        <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      first_idx    <= 4'd0;
      match_count  <= 5'd0;
      match_map    <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          probe <= 4'd0;
          busy  <= 1'b0;
          if (start) begin
            target_q     <= target;
            stop_first_q <= stop_first;
            found        <= 1'b0;
            first_idx    <= 4'd0;
            match_count  <= 5'd0;
            match_map    <= 16'd0;
            busy         <= 1'b1;
            settle_cnt   <= CNT_LOAD;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state <= COMPARE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        COMPARE: begin
          if (hit) begin
            match_map[probe] <= 1'b1;
            match_count      <= match_count + 5'd1;
            if (!found) begin
              first_idx <= probe;
              found     <= 1'b1;
            end
          end
          // probe is left on the last code through DONE; it never wraps.
          if ((hit && stop_first_q) || (probe == 4'd15)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            probe      <= probe + 4'd1;
            settle_cnt <= CNT_LOAD;
            state      <= SETTLE;
          end
        end
        DONE: begin
          probe <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_inverter.sv
// Bench for truth_table_inverter: a response table indexed by probe stands in
// for the function unit; a table-walking reference model predicts results.
module tb_truth_table_inverter;

  localparam int         S    = 2;
  localparam logic [9:0] MASK = 10'b1100111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop_first = 1'b0;
  logic [9:0]  target = 10'd0;
  logic [3:0]  probe;
  logic [9:0]  resp;
  logic        busy, done, found;
  logic [3:0]  first_idx;
  logic [4:0]  match_count;
  logic [15:0] match_map;

  logic [9:0]  resp_tab [16];

  int n_vec = 0;
  int n_bad = 0;

  truth_table_inverter #(.SETTLE_CYCLES(S), .CARE_MASK(MASK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_first(stop_first),
    .target(target), .probe(probe), .resp(resp), .busy(busy), .done(done),
    .found(found), .first_idx(first_idx), .match_count(match_count),
    .match_map(match_map)
  );

  always #5 clk = ~clk;

  assign resp = resp_tab[probe];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one scan, walked code by code over the table.
  int          m_lat;
  logic        m_found;
  logic [3:0]  m_first;
  int          m_count;
  logic [15:0] m_map;

  task automatic model(input logic [9:0] tgt, input logic sf);
    int last;
    m_found = 1'b0; m_first = 4'd0; m_count = 0; m_map = 16'd0; last = 15;
    for (int k = 0; k < 16; k++) begin
      if (((resp_tab[k] ^ tgt) & MASK) == 10'd0) begin
        m_map[k] = 1'b1;
        m_count++;
        if (!m_found) begin
          m_found = 1'b1;
          m_first = 4'(k);
        end
        if (sf) begin
          last = k;
          break;
        end
      end
    end
    m_lat = (last + 1) * (S + 1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_found"}, 32'(found), 32'(m_found));
    chk({tag, "_first"}, 32'(first_idx), 32'(m_first));
    chk({tag, "_count"}, 32'(match_count), 32'(m_count));
    chk({tag, "_map"}, 32'(match_map), 32'(m_map));
  endtask

  // One scan; optionally pokes start and target mid-scan to prove they are ignored.
  task automatic run_scan(input string tag, input logic [9:0] tgt, input logic sf, input bit poke);
    int n;
    bit seen;
    model(tgt, sf);
    @(negedge clk);
    target = tgt; stop_first = sf; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      n = c;
      if (poke && c == 10) begin
        start = 1'b1; target = ~tgt; stop_first = ~sf;
      end else if (poke && c == 11) begin
        start = 1'b0; target = tgt; stop_first = sf;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk({tag, "_probe"}, 32'(probe), 32'((c) / (S + 1)));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(m_lat));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_results(tag);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk({tag, "_no_2nd_done"}, 32'(done), 32'd0);
      chk({tag, "_idle_probe"}, 32'(probe), 32'd0);
    end
    check_results({tag, "_hold"});
  endtask

  initial begin
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'd0;

    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_probe", 32'(probe), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single match: resp = probe*3, target 21 -> code 7
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'(k * 3);
    run_scan("single", 10'd21, 1'b0, 1'b0);

    // Reset mid-scan at probe 5 after a hit at code 2
    model(10'd6, 1'b0);
    @(negedge clk);
    target = 10'd6; stop_first = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (probe == 4'd5) begin
          reached = 1'b1;
          break;
        end
      end
      chk("rst_mid_reach5", 32'(reached), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_probe", 32'(probe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_found", 32'(found), 32'd0);
    chk("rst_mid_first", 32'(first_idx), 32'd0);
    chk("rst_mid_count", 32'(match_count), 32'd0);
    chk("rst_mid_map", 32'(match_map), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_mid_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan("after_rst", 10'd6, 1'b0, 1'b0);

    // Multiple matches, then early stop
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'(k % 4);
    run_scan("multi", 10'd2, 1'b0, 1'b0);
    run_scan("early", 10'd2, 1'b1, 1'b0);

    // Don't-care bits 7:6 set in every response
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'(k * 3) | 10'h0C0;
    run_scan("mask_hit", 10'd21, 1'b0, 1'b0);
    run_scan("mask_miss", 10'd20, 1'b0, 1'b0);

    // Every code matches
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'h3FF;
    run_scan("full", 10'h3FF, 1'b0, 1'b0);

    // start/target/stop_first poked mid-scan
    for (int k = 0; k < 16; k++) resp_tab[k] = 10'(k % 4);
    run_scan("poke", 10'd3, 1'b0, 1'b1);

    // Randomized tables and targets drawn from a small alphabet so hits occur
    for (int r = 0; r < 20; r++) begin
      logic [9:0] t;
      for (int k = 0; k < 16; k++)
        resp_tab[k] = 10'($urandom_range(0, 3)) | (10'($urandom_range(0, 3)) << 6)
                    | ((($urandom_range(0, 7)) == 0) ? 10'h200 : 10'h000);
      t = 10'($urandom_range(0, 3)) | (10'($urandom_range(0, 3)) << 6);
      run_scan("rand", t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
